// File: rtl/multi_mode_ff_bank.sv
// multi_mode_ff_bank
// ------------------
// Bank of WIDTH edge-triggered flip-flops sharing one clock. A runtime mode
// selects D, T, JK or SR behaviour for every channel at once. The SR illegal
// input (S=R=1) holds the channel, sets a sticky per-channel error flag and
// bumps a saturating counter of cycles that contained at least one illegal
// channel.
//
// Ports
//   clk      in   1      rising-edge clock
//   rst      in   1      synchronous active-high reset
//   en       in   1      update enable (0 = q, qbar and err hold)
//   mode     in   2      00=D, 01=T, 10=JK, 11=SR
//   a        in   WIDTH  D / T / J / S per channel
//   b        in   WIDTH  unused / unused / K / R per channel
//   clr_err  in   1      synchronous clear of err and err_cnt (ignores en)
//   q        out  WIDTH  flip-flop state
//   qbar     out  WIDTH  ~q, registered alongside q
//   err      out  WIDTH  sticky SR-illegal flags
//   err_cnt  out  CNT_W  saturating count of illegal cycles
//
// There is no FSM and no handshake; every output is a plain register.
module multi_mode_ff_bank #(
  parameter int              WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int              CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clr_err,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic [WIDTH-1:0] err,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [1:0] MODE_D  = 2'b00;
  localparam logic [1:0] MODE_T  = 2'b01;
  localparam logic [1:0] MODE_JK = 2'b10;
  localparam logic [1:0] MODE_SR = 2'b11;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] illegal_vec;
  logic             illegal_evt;
  logic [WIDTH-1:0] err_next;
  logic [CNT_W-1:0] cnt_next;

  // Per-channel next state. The JK and SR tables are written as bit-wise
  // set/clear masks so every known input pattern yields a known q.
  always_comb begin
    q_next = q;
    if (en) begin
      unique case (mode)
        MODE_D:  q_next = a;
        MODE_T:  q_next = q ^ a;
        // J&~K sets, ~J&K clears, J&K toggles, 00 holds.
        MODE_JK: q_next = (a & ~b) | (~b & q) | (a & b & ~q);
        // S&~R sets, ~S&R clears, 00 and the illegal 11 both hold.
        MODE_SR: q_next = (a & ~b) | (~(a ^ b) & q);
        default: q_next = q;
      endcase
    end
  end

  assign illegal_vec = (en && mode == MODE_SR) ? (a & b) : '0;
  assign illegal_evt = |illegal_vec;

  // A new illegal event outranks clr_err: the clear wipes history but the
  // current cycle's event is still recorded.
  always_comb begin
    err_next = err;
    cnt_next = err_cnt;
    if (illegal_evt) begin
      if (clr_err) begin
        err_next = illegal_vec;
        cnt_next = CNT_ONE;
      end else begin
        err_next = err | illegal_vec;
        // Saturation decided on the pre-increment value.
        cnt_next = (err_cnt == CNT_MAX) ? CNT_MAX : err_cnt + CNT_ONE;
      end
    end else if (clr_err) begin
      err_next = '0;
      cnt_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q       <= RESET_VAL;
      qbar    <= ~RESET_VAL;
      err     <= '0;
      err_cnt <= '0;
    end else begin
      q       <= q_next;
      qbar    <= ~q_next;
      err     <= err_next;
      err_cnt <= cnt_next;
    end
  end

endmodule

// File: tb/tb_multi_mode_ff_bank.sv
// Directed bench for multi_mode_ff_bank with WIDTH=8, RESET_VAL=A5, CNT_W=4.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point, i.e. after the edge that produced them.
module tb_multi_mode_ff_bank;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             clr_err;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qbar;
  logic [WIDTH-1:0] err;
  logic [CNT_W-1:0] err_cnt;

  int vectors     = 0;
  int miscompares = 0;

  multi_mode_ff_bank #(
    .WIDTH    (WIDTH),
    .RESET_VAL(8'hA5),
    .CNT_W    (CNT_W)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .mode   (mode),
    .a      (a),
    .b      (b),
    .clr_err(clr_err),
    .q      (q),
    .qbar   (qbar),
    .err    (err),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // q, qbar (= ~q), err and err_cnt against expected values.
  task automatic check_all(input string tag, input logic [7:0] eq,
                           input logic [7:0] eerr, input logic [3:0] ecnt);
    check({tag, ".q"}, 32'(q), 32'(eq));
    check({tag, ".qbar"}, 32'(qbar), 32'(8'(~eq)));
    check({tag, ".err"}, 32'(err), 32'(eerr));
    check({tag, ".err_cnt"}, 32'(err_cnt), 32'(ecnt));
  endtask

  task automatic drive(input logic r, input logic e, input logic [1:0] m,
                       input logic [7:0] va, input logic [7:0] vb, input logic c);
    rst = r; en = e; mode = m; a = va; b = vb; clr_err = c;
  endtask

  initial begin
    logic [3:0] exp_cnt;
    drive(1'b1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
          8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0);
    #1;

    // Reset with random control inputs.
    step();
    check_all("reset", 8'hA5, 8'h00, 4'd0);

    // Hold after reset.
    drive(1'b0, 1'b0, 2'b00, 8'h00, 8'h00, 1'b0);
    step();
    check_all("hold_after_reset", 8'hA5, 8'h00, 4'd0);

    // D then two T edges.
    drive(1'b0, 1'b1, 2'b00, 8'h3C, 8'hFF, 1'b0);
    step();
    check_all("d_load", 8'h3C, 8'h00, 4'd0);
    drive(1'b0, 1'b1, 2'b01, 8'h0F, 8'h00, 1'b0);
    step();
    check_all("t_first", 8'h33, 8'h00, 4'd0);
    step();
    check_all("t_second", 8'h3C, 8'h00, 4'd0);

    // JK from F0 with J=CC, K=AA:
    // b7 11 tog 1->0, b6 10 set 1, b5 01 clr 0, b4 00 hold 1,
    // b3 11 tog 0->1, b2 10 set 1, b1 01 clr 0, b0 00 hold 0 -> 5C.
    drive(1'b0, 1'b1, 2'b00, 8'hF0, 8'h00, 1'b0);
    step();
    check_all("jk_preload", 8'hF0, 8'h00, 4'd0);
    drive(1'b0, 1'b1, 2'b10, 8'hCC, 8'hAA, 1'b0);
    step();
    check_all("jk", 8'h5C, 8'h00, 4'd0);

    // SR illegal on bit0, set on bit7.
    drive(1'b0, 1'b1, 2'b00, 8'h0F, 8'h00, 1'b0);
    step();
    drive(1'b0, 1'b1, 2'b11, 8'h81, 8'h01, 1'b0);
    step();
    check_all("sr_illegal", 8'h8F, 8'h01, 4'd1);
    drive(1'b0, 1'b1, 2'b11, 8'h00, 8'h00, 1'b0);
    step();
    check_all("sr_sticky", 8'h8F, 8'h01, 4'd1);

    // 17 more illegal cycles on bit0; counter climbs from 1 and sticks at 15.
    drive(1'b0, 1'b1, 2'b11, 8'h01, 8'h01, 1'b0);
    exp_cnt = 4'd1;
    for (int i = 0; i < 17; i++) begin
      step();
      if (exp_cnt != 4'd15) exp_cnt = exp_cnt + 4'd1;
      check("sat_cnt", 32'(err_cnt), 32'(exp_cnt));
    end
    check_all("saturated", 8'h8F, 8'h01, 4'd15);
    step();
    check_all("saturated_stays", 8'h8F, 8'h01, 4'd15);

    // clr_err together with a new event on bit1: the event wins.
    drive(1'b0, 1'b1, 2'b11, 8'h02, 8'h02, 1'b1);
    step();
    check_all("clr_with_event", 8'h8F, 8'h02, 4'd1);

    // clr_err alone, en=0 so q holds.
    drive(1'b0, 1'b0, 2'b00, 8'h00, 8'h00, 1'b1);
    step();
    check_all("clr_alone", 8'h8F, 8'h00, 4'd0);

    // Seed one event on bit2 so the gating check has something to hold.
    drive(1'b0, 1'b1, 2'b11, 8'h04, 8'h04, 1'b0);
    step();
    check_all("seed_event", 8'h8F, 8'h04, 4'd1);

    // en=0 with an otherwise illegal pattern: nothing moves.
    drive(1'b0, 1'b0, 2'b11, 8'hFF, 8'hFF, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_all("en_gated", 8'h8F, 8'h04, 4'd1);
    end

    // Reset beats a pending D update on the same edge.
    drive(1'b1, 1'b1, 2'b00, 8'h55, 8'h00, 1'b0);
    step();
    check_all("reset_wins", 8'hA5, 8'h00, 4'd0);

    // First edge after reset updates normally.
    drive(1'b0, 1'b1, 2'b00, 8'h55, 8'h00, 1'b0);
    step();
    check_all("post_reset_d", 8'h55, 8'h00, 4'd0);

    // SR set/clear without illegal bits: S=F0, R=0F from 55 -> F0.
    drive(1'b0, 1'b1, 2'b11, 8'hF0, 8'h0F, 1'b0);
    step();
    check_all("sr_set_clr", 8'hF0, 8'h00, 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
